serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around a chained half-adder pair plus a carry flop.
//  Computes one sum bit per clock, LSB first.
//  Consumes two parallel operands on a start handshake and returns a registered sum
//  and carry-out with a one-cycle done pulse.
//  Sits downstream of operand registers and feeds the half_adder datapath one bit at a time.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; legal range 1..32
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  rst_n      in   1      synchronous active-low reset, sampled on rising clk
//  start      in   1      request to add a,b; honoured only when busy==0
//  a          in   WIDTH  operand A, sampled on the accepting edge only
//  b          in   WIDTH  operand B, sampled on the accepting edge only
//  busy       out  1      1 while an addition is in progress (RUN state)
//  done       out  1      one-cycle pulse: sum/carry_out just updated
//  sum        out  WIDTH  result register (a+b) mod 2^WIDTH
//  carry_out  out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//  Reset (rst_n==0 at a rising edge):
//   - state=IDLE; busy=0, done=0, sum=0, carry_out=0.
//   - Internal shift registers, bit counter and carry flop cleared.
//   - Reset during RUN aborts the addition; no done pulse; result is not updated.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 -> RUN. Load shA<=a, shB<=b, cnt<=0, c<=0. Else stay in IDLE.
//   - RUN, per edge:
//     - s = shA[0]^shB[0]^c
//     - c <= (shA[0]&shB[0]) | (c&(shA[0]^shB[0]))
//     - shA, shB shift right by 1
//     - shS <= {s, shS[WIDTH-1:1]}
//     - cnt <= cnt+1
//   - RUN exit: on the edge where cnt==WIDTH-1, state->DONE, sum<={s,shS[WIDTH-1:1]},
//     carry_out<=next c, done<=1.
//   - DONE: done=1 for exactly this cycle.
//     - start=1 -> RUN with a new load (back-to-back).
//     - Otherwise -> IDLE.
//   - done is 0 in every other state.
//  busy: 1 in RUN only; 0 in IDLE and DONE. start is ignored while busy=1
//   (no queuing, operands not resampled).
//  Latency: start accepted at edge E0 -> done high in the cycle following edge E0+WIDTH.
//   Throughput is one result per WIDTH+1 cycles.
//  Result hold: sum/carry_out change only at the RUN->DONE edge or on reset.
//   During RUN they keep the previous result.
//  Width rules:
//   - cnt width = $clog2(WIDTH+1).
//   - No overflow flag; overflow is reported solely via carry_out.
//   - WIDTH==1 degenerates to one RUN cycle; a full-adder with c=0 equals a half adder.
// TESTING
//  1 Reset: rst_n=0 for 2 clks -> busy=0, done=0, sum=8'h00, carry_out=0.
//  2 a=8'hFF, b=8'h01, start 1 clk -> busy=1 for 8 clks; done 1 clk;
//    sum=8'h00, carry_out=1.
//  3 a=8'hA5, b=8'h5A -> sum=8'hFF, carry_out=0.
//    Raise start with a=8'h01,b=8'h01 mid-RUN -> ignored; result still 8'hFF.
//  4 Back-to-back: start held high.
//    - 8'h80+8'h80 -> sum=8'h00, carry_out=1.
//    - Second op 8'h0F+8'h01 accepted in the DONE cycle -> sum=8'h10, carry_out=0.
//    - Second done follows the first by 9 clks.
//  5 Reset mid-op: start 8'h7F+8'h01, drop rst_n on 4th RUN cycle.
//    -> no done; sum=8'h00, carry_out=0; busy=0 next cycle.
//  6 WIDTH=1: exhaustive a,b in {0,1}.
//    -> {carry_out,sum} = 00,01,01,10 (half-adder truth table); done 1 clk after accept.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one sum bit per clock, LSB first.
//
// A start request in IDLE or DONE loads both operands, after which the adder spends WIDTH
// cycles in RUN. Each RUN cycle pushes the low bit of each operand through a chained pair of
// half adders plus a carry flop. The cycle after the last bit, the design sits in DONE for
// exactly one cycle, with done_o high and the new sum_o/carry_out_o visible.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset, sampled on the rising clock edge
//   start_i      request to add a_i + b_i; honoured only when busy_o is low
//   a_i, b_i     operands, sampled on the accepting edge only
//   busy_o       high while the addition is in progress (RUN)
//   done_o       one-cycle pulse: sum_o/carry_out_o were just updated
//   sum_o        registered result, (a + b) mod 2^WIDTH
//   carry_out_o  registered carry out of bit WIDTH-1

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o
);

    localparam int unsigned        CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0]    CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operand A doubles as the partial-sum shift register: each sum bit enters the MSB that
    // the right shift just vacated, so after WIDTH shifts it holds the complete sum.
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic accept;
    logic last_bit;

    // Bit-slice datapath: two chained half adders plus an OR form the full adder.
    logic ha0_s, ha0_c;
    logic ha1_s, ha1_c;
    logic bit_sum, bit_carry;
    logic [WIDTH-1:0] sh_a_next;

    assign ha0_s     = sh_a_q[0] ^ sh_b_q[0];
    assign ha0_c     = sh_a_q[0] & sh_b_q[0];
    assign ha1_s     = ha0_s ^ c_q;
    assign ha1_c     = ha0_s & c_q;
    assign bit_sum   = ha1_s;
    assign bit_carry = ha0_c | ha1_c;

    if (WIDTH > 1) begin : g_wide
        assign sh_a_next = {bit_sum, sh_a_q[WIDTH-1:1]};
    end else begin : g_single
        assign sh_a_next = bit_sum;
    end

    // Operands are only taken when not busy; a start seen in DONE chains straight into RUN.
    assign accept   = start_i && (state_q != StRun);
    assign last_bit = (state_q == StRun) && (cnt_q == CntLast);

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StRun;
            StRun:  if (last_bit) state_d = StDone;
            StDone: state_d = start_i ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values. The result registers move only on the final RUN edge.
    always_comb begin
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (accept) begin
            sh_a_d = a_i;
            sh_b_d = b_i;
            cnt_d  = '0;
            c_d    = 1'b0;
        end else if (state_q == StRun) begin
            sh_a_d = sh_a_next;
            sh_b_d = sh_b_q >> 1;
            cnt_d  = cnt_q + CntW'(1);
            c_d    = bit_carry;
            if (last_bit) begin
                sum_d   = sh_a_next;
                carry_d = bit_carry;
            end
        end
    end

    // Outputs decode straight from registered state.
    always_comb begin
        busy_o      = (state_q == StRun);
        done_o      = (state_q == StDone);
        sum_o       = sum_q;
        carry_out_o = carry_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance and a 1-bit instance share clock
// and reset. Expected {carry, sum} values are pushed when an operation is launched and
// popped when done is observed.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] sum;
    logic       carry_out;

    logic       start1;
    logic [0:0] a1, b1;
    logic       busy1, done1;
    logic [0:0] sum1;
    logic       carry_out1;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .a_i        (a),
        .b_i        (b),
        .busy_o     (busy),
        .done_o     (done),
        .sum_o      (sum),
        .carry_out_o(carry_out)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start1),
        .a_i        (a1),
        .b_i        (b1),
        .busy_o     (busy1),
        .done_o     (done1),
        .sum_o      (sum1),
        .carry_out_o(carry_out1)
    );

    // Launch one 8-bit operation for a single cycle and record the expected result.
    task automatic launch(input logic [7:0] op_a, input logic [7:0] op_b);
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        exp_q.push_back({1'b0, op_a} + {1'b0, op_b});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges up to and including the one where done is seen.
    task automatic wait_done(input bit w1, output int cycles, output int busy_cnt,
                             output bit timed_out);
        cycles    = 0;
        busy_cnt  = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cycles++;
            if (w1 ? busy1 : busy) busy_cnt++;
            if (w1 ? done1 : done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        a = '0; b = '0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b want=0", done);
        end
        checks++;
        if (sum !== 8'h00) begin
            failures++; $display("FAIL reset_sum got=%h want=00", sum);
        end
        checks++;
        if (carry_out !== 1'b0) begin
            failures++; $display("FAIL reset_carry got=%b want=0", carry_out);
        end
    endtask

    task automatic test_overflow;
        int cyc, bcnt;
        bit to;
        logic [8:0] e;
        launch(8'hFF, 8'h01);
        wait_done(1'b0, cyc, bcnt, to);
        checks++;
        if (to) begin
            failures++; $display("FAIL ovf_timeout got=no_done want=done");
        end
        e = exp_q.pop_front();
        checks++;
        if ({carry_out, sum} !== e) begin
            failures++; $display("FAIL ovf_result got=%h want=%h", {carry_out, sum}, e);
        end
        checks++;
        if (bcnt != 8) begin
            failures++; $display("FAIL ovf_busy_cycles got=%0d want=8", bcnt);
        end
        checks++;
        if (cyc != 9) begin
            failures++; $display("FAIL ovf_latency got=%0d want=9", cyc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL ovf_pulse got=done%b busy%b want=done0 busy0", done, busy);
        end
    endtask

    task automatic test_ignore_start;
        int cyc, bcnt;
        bit to;
        logic [8:0] e;
        bit extra;
        launch(8'hA5, 8'h5A);
        repeat (3) @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, cyc, bcnt, to);
        checks++;
        if (to) begin
            failures++; $display("FAIL ign_timeout got=no_done want=done");
        end
        e = exp_q.pop_front();
        checks++;
        if ({carry_out, sum} !== e) begin
            failures++; $display("FAIL ign_result got=%h want=%h", {carry_out, sum}, e);
        end
        extra = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            failures++; $display("FAIL ign_no_rerun got=activity want=idle");
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt;
        bit to;
        logic [8:0] e;
        @(negedge clk);
        start = 1'b1; a = 8'h80; b = 8'h80;
        exp_q.push_back(9'h100);
        @(posedge clk);
        #1 a = 8'h0F; b = 8'h01;
        exp_q.push_back(9'h010);
        wait_done(1'b0, cyc, bcnt, to);
        checks++;
        if (to) begin
            failures++; $display("FAIL b2b_first_timeout got=no_done want=done");
        end
        e = exp_q.pop_front();
        checks++;
        if ({carry_out, sum} !== e) begin
            failures++; $display("FAIL b2b_first got=%h want=%h", {carry_out, sum}, e);
        end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1'b0, cyc, bcnt, to);
        checks++;
        if (to) begin
            failures++; $display("FAIL b2b_second_timeout got=no_done want=done");
        end
        e = exp_q.pop_front();
        checks++;
        if ({carry_out, sum} !== e) begin
            failures++; $display("FAIL b2b_second got=%h want=%h", {carry_out, sum}, e);
        end
        checks++;
        if (cyc != 9) begin
            failures++; $display("FAIL b2b_gap got=%0d want=9", cyc);
        end
        checks++;
        if (bcnt != 8) begin
            failures++; $display("FAIL b2b_busy got=%0d want=8", bcnt);
        end
    endtask

    task automatic test_random;
        int cyc, bcnt;
        bit to;
        logic [8:0] e;
        for (int i = 0; i < 6; i++) begin
            launch(8'($urandom_range(255)), 8'($urandom_range(255)));
            wait_done(1'b0, cyc, bcnt, to);
            e = exp_q.pop_front();
            checks++;
            if (to || {carry_out, sum} !== e) begin
                failures++;
                $display("FAIL rand_%0d got=%h want=%h timeout=%0d", i, {carry_out, sum}, e, to);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        @(negedge clk);
        start = 1'b1; a = 8'h7F; b = 8'h01;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL mid_rst_state got=busy%b done%b want=busy0 done0", busy, done);
        end
        checks++;
        if ({carry_out, sum} !== 9'h000) begin
            failures++; $display("FAIL mid_rst_result got=%h want=000", {carry_out, sum});
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL mid_rst_no_done got=done want=none");
        end
    endtask

    task automatic test_width1;
        int cyc, bcnt;
        bit to;
        logic [1:0] e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start1 = 1'b1;
            a1     = 1'(i >> 1);
            b1     = 1'(i);
            exp1_q.push_back({1'b0, a1} + {1'b0, b1});
            @(posedge clk);
            #1 start1 = 1'b0;
            wait_done(1'b1, cyc, bcnt, to);
            e = exp1_q.pop_front();
            checks++;
            if (to || {carry_out1, sum1} !== e) begin
                failures++;
                $display("FAIL w1_result_%0d got=%b want=%b timeout=%0d", i,
                         {carry_out1, sum1}, e, to);
            end
            checks++;
            if (cyc != 2 || bcnt != 1) begin
                failures++;
                $display("FAIL w1_latency_%0d got=cyc%0d busy%0d want=cyc2 busy1", i, cyc, bcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
